// File: rtl/pixel_fifo_reader_pkg.sv
// Shared types and constants for the pixel FIFO read-side controller.
// The data field of a buffer entry follows the top-level DATA_W and is packed beside pix_flags_t.
package pixel_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    BURST     = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } pix_flags_t;

  localparam int SKID_DEPTH   = 2;
  localparam int READ_LATENCY = 1;
  localparam int FLAG_W       = $bits(pix_flags_t);

  // Counter width that stays at least one bit for a count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry valid/ready buffer. There is no input ready: the writer limits
// itself with the count output, so a push never finds the buffer full.
module pix_skid_buf #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       do_push;
  logic       do_pop;

  assign out_valid = (count_reg != 2'd0);
  assign count     = count_reg;
  assign do_pop    = out_valid & out_ready;
  // A full buffer may still take a word in the cycle it releases its head.
  assign do_push   = push & ((count_reg != 2'd2) | do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          entry_reg <= '0;
        else if (do_push && (wr_ptr_reg == 1'(gi)))
          entry_reg <= push_data;
      end
    end
  endgenerate

  assign out_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (clr) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pixel_fifo_reader.sv
// Read-side controller for the pixel SCFIFO: waits for a full line, then
// streams it out with line/frame framing, abort/flush and underrun status.
module pixel_fifo_reader
  import pixel_fifo_reader_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int USEDW_W = 11,
  parameter int LINE_W  = 640,
  parameter int LINES   = 480
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  fifo_dataout,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               fifo_rdreq,
  output logic               fifo_sclr,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_sol,
  output logic               m_eol,
  output logic               m_sof,
  output logic               m_eof,
  output logic               busy,
  output logic               underrun_err
);

  localparam int COL_W   = cnt_width(LINE_W);
  localparam int ROW_W   = cnt_width(LINES);
  localparam int ENTRY_W = DATA_W + FLAG_W;
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(LINES - 1);
  localparam logic [USEDW_W:0]   AVAIL_FULL = (USEDW_W + 1)'(2 ** USEDW_W);
  localparam logic [USEDW_W:0]   LINE_NEED  = (USEDW_W + 1)'(LINE_W);

  state_t             state_reg;
  state_t             state_next;
  logic [COL_W-1:0]   col_reg;
  logic [ROW_W-1:0]   row_reg;
  logic               inflight_reg;
  pix_flags_t         tag_reg;
  logic               underrun_reg;

  pix_flags_t         issue_tag;
  pix_flags_t         head_flags;
  logic [USEDW_W:0]   avail;
  logic [1:0]         skid_count;
  logic [2:0]         occupancy;
  logic               skid_pop;
  logic               line_done;
  logic               start_ok;
  logic [ENTRY_W-1:0] skid_in;
  logic [ENTRY_W-1:0] skid_out;

  // usedw wraps to 0 when the FIFO is completely full.
  assign avail    = fifo_full ? AVAIL_FULL : {1'b0, fifo_usedw};
  assign start_ok = (state_reg == IDLE) & start & ~abort;
  assign skid_pop = m_valid & m_ready;

  // Words that will still be held once this cycle's accept leaves; counting the
  // accept lets a new read issue every cycle while m_ready stays high.
  assign occupancy  = {1'b0, skid_count} + {2'b00, inflight_reg} - {2'b00, skid_pop};
  assign fifo_rdreq = (state_reg == BURST) & ~abort & ~fifo_empty &
                      (occupancy < 3'(SKID_DEPTH));
  assign line_done  = fifo_rdreq & (col_reg == COL_LAST);
  assign fifo_sclr  = abort;

  always_comb begin
    issue_tag     = '0;
    issue_tag.sol = (col_reg == '0);
    issue_tag.eol = (col_reg == COL_LAST);
    issue_tag.sof = issue_tag.sol & (row_reg == '0);
    issue_tag.eof = issue_tag.eol & (row_reg == ROW_LAST);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start) state_next = WAIT_LINE;
      WAIT_LINE: if (avail >= LINE_NEED) state_next = BURST;
      BURST:     if (line_done) state_next = (row_reg == ROW_LAST) ? DRAIN : WAIT_LINE;
      DRAIN:     if (skid_pop && head_flags.eof) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (abort || start_ok) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (fifo_rdreq) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

  // Tags travel with the read so the word returning next cycle is framed correctly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_reg <= 1'b0;
      tag_reg      <= '0;
    end else begin
      inflight_reg <= fifo_rdreq;
      if (fifo_rdreq) tag_reg <= issue_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underrun_reg <= 1'b0;
    else if (start_ok)
      underrun_reg <= 1'b0;
    else if ((state_reg == BURST) && fifo_empty)
      underrun_reg <= 1'b1;
  end

  assign skid_in = {fifo_dataout, tag_reg};

  pix_skid_buf #(
    .W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (abort),
    .push      (inflight_reg & ~abort),
    .push_data (skid_in),
    .out_valid (m_valid),
    .out_data  (skid_out),
    .out_ready (m_ready),
    .count     (skid_count)
  );

  assign head_flags   = skid_out[FLAG_W-1:0];
  assign m_data       = skid_out[ENTRY_W-1:FLAG_W];
  assign m_sol        = head_flags.sol;
  assign m_eol        = head_flags.eol;
  assign m_sof        = head_flags.sof;
  assign m_eof        = head_flags.eof;
  assign busy         = (state_reg != IDLE);
  assign underrun_err = underrun_reg;

endmodule

// File: tb/tb_pixel_fifo_reader.sv
// Directed bench for pixel_fifo_reader with a 1-cycle-latency SCFIFO model,
// LINE_W=4 and LINES=2. Beat flags are packed as {sol, eol, sof, eof}.
module tb_pixel_fifo_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  fifo_dataout;
  logic [10:0] fifo_usedw;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        fifo_sclr;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sol, m_eol, m_sof, m_eof;
  logic        busy;
  logic        underrun_err;

  always #5 clk = ~clk;

  pixel_fifo_reader #(
    .DATA_W (8), .USEDW_W (11), .LINE_W (4), .LINES (2)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start (start), .abort (abort),
    .fifo_dataout (fifo_dataout), .fifo_usedw (fifo_usedw),
    .fifo_full (fifo_full), .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq), .fifo_sclr (fifo_sclr),
    .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready),
    .m_sol (m_sol), .m_eol (m_eol), .m_sof (m_sof), .m_eof (m_eof),
    .busy (busy), .underrun_err (underrun_err)
  );

  // FIFO model: show-ahead off, q valid the cycle after rdreq.
  logic [7:0]  fmem [0:2047];
  logic [10:0] f_wp, f_rp;
  int          f_cnt;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        force_empty;

  assign fifo_usedw = f_cnt[10:0];
  assign fifo_full  = (f_cnt == 2048);
  assign fifo_empty = (f_cnt == 0) || force_empty;

  always @(posedge clk) begin
    if (!reset_n || fifo_sclr) begin
      f_wp <= 11'd0;
      f_rp <= 11'd0;
      f_cnt <= 0;
      fifo_dataout <= 8'h00;
    end else begin
      if (fifo_rdreq && f_cnt > 0) begin
        fifo_dataout <= fmem[f_rp];
        f_rp <= f_rp + 11'd1;
      end
      if (wr_en && f_cnt < 2048) begin
        fmem[f_wp] <= wr_data;
        f_wp <= f_wp + 11'd1;
      end
      f_cnt <= f_cnt + ((wr_en && f_cnt < 2048) ? 1 : 0) - ((fifo_rdreq && f_cnt > 0) ? 1 : 0);
    end
  end

  // Monitor: logs accepted beats and issued reads, watches protocol rules.
  int         cyc = 0;
  logic [7:0] beat_data  [0:4095];
  logic [3:0] beat_flags [0:4095];
  int         beat_cyc   [0:4095];
  int         rd_cyc     [0:4095];
  int         beat_cnt = 0;
  int         rd_cnt = 0;
  int         rd_empty_viol = 0;
  int         stall_err = 0;
  int         ovf_err = 0;
  int         outst = 0;
  logic       busy_at_eof = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_sclr = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [3:0] prev_flags = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      beat_data[beat_cnt]  <= m_data;
      beat_flags[beat_cnt] <= {m_sol, m_eol, m_sof, m_eof};
      beat_cyc[beat_cnt]   <= cyc;
      beat_cnt <= beat_cnt + 1;
      if (m_eof) busy_at_eof <= busy;
      $display("beat %0d cyc=%0d data=0x%02h sol=%0b eol=%0b sof=%0b eof=%0b",
               beat_cnt, cyc, m_data, m_sol, m_eol, m_sof, m_eof);
    end
    if (fifo_rdreq) begin
      rd_cyc[rd_cnt] <= cyc;
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
    end
    if (prev_stall && !prev_sclr && reset_n &&
        (!m_valid || m_data != prev_data || {m_sol, m_eol, m_sof, m_eof} != prev_flags))
      stall_err <= stall_err + 1;
    prev_stall <= m_valid & ~m_ready;
    prev_sclr  <= fifo_sclr | ~reset_n;
    prev_data  <= m_data;
    prev_flags <= {m_sol, m_eol, m_sof, m_eof};
    if (outst > 2) ovf_err <= ovf_err + 1;
    outst <= (fifo_sclr || !reset_n) ? 0 :
             outst + (fifo_rdreq ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n = 0;
    while (beat_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (beat_cnt < target) check_val(tag, 32'(beat_cnt), 32'(target));
  endtask

  task automatic wait_reads(input int target, input int budget, input string tag);
    int n = 0;
    while (rd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (rd_cnt < target) check_val(tag, 32'(rd_cnt), 32'(target));
  endtask

  // Hand-tabulated framing for a 4x2 frame, indexed by beat position in the frame.
  function automatic logic [3:0] exp_flags(input int i);
    case (i % 8)
      0:       return 4'b1010;
      3:       return 4'b0100;
      4:       return 4'b1000;
      7:       return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check_frame(input int bb, input int first, input int n,
                             input logic [7:0] base, input string tag);
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_data"}, 32'(beat_data[bb + i]), 32'(base + 8'(i)));
      check_val({tag, "_flags"}, 32'(beat_flags[bb + i]), 32'(exp_flags(first + i)));
    end
  endtask

  initial begin
    int bb;
    int rb;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    m_ready = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    force_empty = 1'b0;
    repeat (3) tick();

    check_val("rst_valid", 32'(m_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    check_val("rst_sclr", 32'(fifo_sclr), 32'd0);
    check_val("rst_underrun", 32'(underrun_err), 32'd0);
    check_val("rst_flags", 32'({m_data, m_sol, m_eol, m_sof, m_eof}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Full 4x2 frame at full rate.
    m_ready = 1'b1;
    push_words(8, 8'h10);
    bb = beat_cnt;
    pulse_start();
    wait_beats(bb + 8, 60, "t1_timeout");
    check_frame(bb, 0, 8, 8'h10, "t1");
    check_val("t1_busy_at_eof", 32'(busy_at_eof), 32'd1);
    check_val("t1_busy_after", 32'(busy), 32'd0);
    check_val("t1_underrun", 32'(underrun_err), 32'd0);

    // Line threshold: three words are not enough.
    push_words(3, 8'h20);
    pulse_start();
    rb = rd_cnt;
    bb = beat_cnt;
    repeat (5) tick();
    check_val("t2_no_rdreq", 32'(rd_cnt - rb), 32'd0);
    check_val("t2_busy", 32'(busy), 32'd1);
    push_words(1, 8'h23);
    wait_beats(bb + 4, 30, "t2_timeout");
    repeat (4) tick();
    check_val("t2_rd_count", 32'(rd_cnt - rb), 32'd4);
    check_val("t2_rd_span", 32'(rd_cyc[rb + 3] - rd_cyc[rb]), 32'd3);
    check_val("t2_latency", 32'(beat_cyc[bb] - rd_cyc[rb]), 32'd2);
    check_frame(bb, 0, 4, 8'h20, "t2");

    // Second line under a toggling m_ready.
    m_ready = 1'b0;
    push_words(4, 8'h24);
    begin
      int n = 0;
      while (beat_cnt < bb + 8 && n < 60) begin
        m_ready = ~m_ready;
        tick();
        n++;
      end
    end
    check_val("t3_count", 32'(beat_cnt - bb), 32'd8);
    check_frame(bb + 4, 4, 4, 8'h24, "t3");
    m_ready = 1'b1;
    repeat (2) tick();
    check_val("t3_stall_stable", 32'(stall_err), 32'd0);
    check_val("t3_outstanding", 32'(ovf_err), 32'd0);
    check_val("t3_idle", 32'(busy), 32'd0);

    // Completely full FIFO: usedw reads 0 but a burst must still start.
    for (int i = 0; i < 2048; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    rb = rd_cnt;
    bb = beat_cnt;
    pulse_start();
    wait_beats(bb + 1, 20, "t4_timeout");
    check_val("t4_burst", 32'(rd_cnt > rb), 32'd1);
    check_val("t4_first_data", 32'(beat_data[bb]), 32'h00);
    check_val("t4_first_flags", 32'(beat_flags[bb]), 32'(4'b1010));
    m_ready = 1'b0;
    abort = 1'b1;
    #1;
    check_val("t4_sclr", 32'(fifo_sclr), 32'd1);
    tick();
    abort = 1'b0;
    #1;
    check_val("t4_valid_drop", 32'(m_valid), 32'd0);
    check_val("t4_idle", 32'(busy), 32'd0);

    // Abort after two of four pixels, then a clean frame.
    m_ready = 1'b1;
    push_words(8, 8'h30);
    bb = beat_cnt;
    pulse_start();
    wait_beats(bb + 2, 30, "t5_timeout");
    m_ready = 1'b0;
    abort = 1'b1;
    #1;
    check_val("t5_sclr_hi", 32'(fifo_sclr), 32'd1);
    tick();
    abort = 1'b0;
    #1;
    check_val("t5_sclr_lo", 32'(fifo_sclr), 32'd0);
    check_val("t5_valid_drop", 32'(m_valid), 32'd0);
    check_val("t5_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    check_val("t5_discard", 32'(m_valid), 32'd0);
    check_val("t5_beats", 32'(beat_cnt - bb), 32'd2);
    m_ready = 1'b1;
    push_words(8, 8'h40);
    bb = beat_cnt;
    pulse_start();
    wait_beats(bb + 8, 60, "t5b_timeout");
    check_frame(bb, 0, 8, 8'h40, "t5b");

    // Underrun: empty forced for three cycles mid-line.
    push_words(8, 8'h50);
    rb = rd_cnt;
    bb = beat_cnt;
    pulse_start();
    wait_reads(rb + 2, 20, "t6_rd_timeout");
    force_empty = 1'b1;
    repeat (3) tick();
    force_empty = 1'b0;
    check_val("t6_underrun_set", 32'(underrun_err), 32'd1);
    wait_beats(bb + 8, 60, "t6_timeout");
    check_frame(bb, 0, 8, 8'h50, "t6");
    check_val("t6_sticky", 32'(underrun_err), 32'd1);
    pulse_start();
    check_val("t6_cleared", 32'(underrun_err), 32'd0);

    // Asynchronous reset in the middle of a burst.
    bb = beat_cnt;
    push_words(8, 8'h60);
    wait_beats(bb + 1, 30, "t7_timeout");
    #2;
    reset_n = 1'b0;
    #1;
    check_val("t7_valid", 32'(m_valid), 32'd0);
    check_val("t7_busy", 32'(busy), 32'd0);
    check_val("t7_rdreq", 32'(fifo_rdreq), 32'd0);
    check_val("t7_outputs", 32'({m_data, m_sol, m_eol, m_sof, m_eof}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    check_val("rdreq_while_empty", 32'(rd_empty_viol), 32'd0);
    check_val("stall_stable", 32'(stall_err), 32'd0);
    check_val("max_outstanding", 32'(ovf_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
